// File: rtl/csr_bank_pkg.sv
// csr_bank_pkg: shared constants for the CSR bank.
// Holds op encodings and the per-channel handshake state type.
package csr_bank_pkg;

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_SET    = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

endpackage

// File: rtl/csr_reg_slice.sv
// csr_reg_slice: one CSR channel with req/ack FSM, op ALU, register.
// Ports: clock, reset, req/ack, op, wdata, wmask, lock, data_out, upd, err.
module csr_reg_slice
    import csr_bank_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter bit                    PULSE      = 1'b0,
    parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req,
    output logic                  ack,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] wmask,
    input  logic                  lock,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  upd,
    output logic                  err
);

    localparam logic [DATA_WIDTH-1:0] IDLE_VAL = PULSE ? '0 : RST_VAL;

    state_t                state;
    logic [DATA_WIDTH-1:0] base;
    logic [DATA_WIDTH-1:0] d;
    logic [DATA_WIDTH-1:0] nxt;

    // Pulse channels compute from zero so a commit never leaks history.
    assign base = PULSE ? '0 : data_out;
    assign d    = wdata & wmask;

    always_comb begin
        nxt = base;
        unique case (op)
            OP_WRITE:  nxt = (base & ~wmask) | d;
            OP_SET:    nxt = base | d;
            OP_CLEAR:  nxt = base & ~d;
            OP_TOGGLE: nxt = base ^ d;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            ack      <= 1'b0;
            upd      <= 1'b0;
            err      <= 1'b0;
            data_out <= IDLE_VAL;
        end else begin
            upd <= 1'b0;
            err <= 1'b0;
            // Pulse value lasts one cycle unless overwritten below.
            if (PULSE) begin
                data_out <= '0;
            end
            unique case (state)
                ST_IDLE: begin
                    if (req) begin
                        state <= ST_ACK;
                        ack   <= 1'b1;
                    end
                end
                ST_ACK: begin
                    state <= ST_IDLE;
                    ack   <= 1'b0;
                    if (req) begin
                        if (lock) begin
                            err <= 1'b1;
                        end else begin
                            upd      <= 1'b1;
                            data_out <= nxt;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/csr_bank.sv
// csr_bank: NUM_REGS independent CSR channels, flattened vector ports.
// Ports: clock, reset, req/ack, op, wdata, wmask, lock, data_out, upd, err.
module csr_bank
    import csr_bank_pkg::*;
#(
    parameter int                             NUM_REGS    = 3,
    parameter int                             DATA_WIDTH  = 32,
    parameter logic [NUM_REGS-1:0]            PULSE_MASK  = NUM_REGS'(1),
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REGS-1:0]            req,
    output logic [NUM_REGS-1:0]            ack,
    input  logic [2*NUM_REGS-1:0]          op,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] wdata,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] wmask,
    input  logic [NUM_REGS-1:0]            lock,
    output logic [NUM_REGS*DATA_WIDTH-1:0] data_out,
    output logic [NUM_REGS-1:0]            upd,
    output logic [NUM_REGS-1:0]            err
);

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_ch
        csr_reg_slice #(
            .DATA_WIDTH (DATA_WIDTH),
            .PULSE      (PULSE_MASK[i]),
            .RST_VAL    (RESET_VALUE[i*DATA_WIDTH +: DATA_WIDTH])
        ) u_slice (
            .clock    (clock),
            .reset    (reset),
            .req      (req[i]),
            .ack      (ack[i]),
            .op       (op[2*i +: 2]),
            .wdata    (wdata[i*DATA_WIDTH +: DATA_WIDTH]),
            .wmask    (wmask[i*DATA_WIDTH +: DATA_WIDTH]),
            .lock     (lock[i]),
            .data_out (data_out[i*DATA_WIDTH +: DATA_WIDTH]),
            .upd      (upd[i]),
            .err      (err[i])
        );
    end

endmodule

// File: tb/tb_csr_bank.sv
// tb_csr_bank: directed self-checking bench for csr_bank.
// Expected commits are queued at drive time and popped at the commit edge.
module tb_csr_bank;

    localparam int N = 3;
    localparam int W = 32;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req   = '0;
    logic [N-1:0]   ack;
    logic [2*N-1:0] op    = '0;
    logic [N*W-1:0] wdata = '0;
    logic [N*W-1:0] wmask = '0;
    logic [N-1:0]   lock  = '0;
    logic [N*W-1:0] data_out;
    logic [N-1:0]   upd;
    logic [N-1:0]   err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          ch;
        logic        is_err;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    csr_bank #(
        .NUM_REGS    (N),
        .DATA_WIDTH  (W),
        .PULSE_MASK  (3'b001),
        .RESET_VALUE ({32'hA5A5_0000, 32'h0000_00FF, 32'h0})
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .ack      (ack),
        .op       (op),
        .wdata    (wdata),
        .wmask    (wmask),
        .lock     (lock),
        .data_out (data_out),
        .upd      (upd),
        .err      (err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] dval(input int ch);
        return data_out[ch*W +: W];
    endfunction

    task automatic drive(input int ch, input logic [1:0] o,
                         input logic [31:0] d, input logic [31:0] m,
                         input logic lk, input logic [31:0] exp_val);
        exp_t e;
        op[2*ch +: 2]    = o;
        wdata[ch*W +: W] = d;
        wmask[ch*W +: W] = m;
        lock[ch]         = lk;
        req[ch]          = 1'b1;
        e.ch     = ch;
        e.is_err = lk;
        e.val    = exp_val;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_upd"}, {31'd0, upd[e.ch]}, {31'd0, ~e.is_err});
        chk({tag, "_err"}, {31'd0, err[e.ch]}, {31'd0, e.is_err});
        chk({tag, "_ack"}, {31'd0, ack[e.ch]}, 32'd0);
        chk({tag, "_data"}, dval(e.ch), e.val);
    endtask

    // Single transaction on one channel, checking latency and strobes.
    task automatic txn(input string tag, input int ch, input logic [1:0] o,
                       input logic [31:0] d, input logic [31:0] m,
                       input logic lk, input logic [31:0] exp_val,
                       input logic [31:0] after_val);
        drive(ch, o, d, m, lk, exp_val);
        tick();
        chk({tag, "_e0_ack"}, {31'd0, ack[ch]}, 32'd1);
        chk({tag, "_e0_upd"}, {31'd0, upd[ch]}, 32'd0);
        tick();
        pop_chk(tag);
        req[ch]  = 1'b0;
        lock[ch] = 1'b0;
        tick();
        chk({tag, "_e2_upd"}, {31'd0, upd[ch]}, 32'd0);
        chk({tag, "_e2_err"}, {31'd0, err[ch]}, 32'd0);
        chk({tag, "_e2_data"}, dval(ch), after_val);
    endtask

    initial begin
        repeat (2) tick();
        reset = 1'b0;
        tick();
        #3 reset = 1'b1;
        #1;
        chk("rst_d0", dval(0), 32'h0);
        chk("rst_d1", dval(1), 32'h0000_00FF);
        chk("rst_d2", dval(2), 32'hA5A5_0000);
        chk("rst_ack", {29'd0, ack}, 32'd0);
        chk("rst_upd", {29'd0, upd}, 32'd0);
        chk("rst_err", {29'd0, err}, 32'd0);
        #2 reset = 1'b0;
        tick();

        txn("wr1", 1, 2'b00, 32'h1234_5678, 32'hFFFF_0000, 1'b0,
            32'h1234_00FF, 32'h1234_00FF);
        txn("set1", 1, 2'b01, 32'h0000_000F, 32'hFFFF_FFFF, 1'b0,
            32'h1234_00FF, 32'h1234_00FF);
        txn("clr1", 1, 2'b10, 32'h0000_00F0, 32'hFFFF_FFFF, 1'b0,
            32'h1234_000F, 32'h1234_000F);
        txn("tgl1", 1, 2'b11, 32'h0000_0003, 32'hFFFF_FFFF, 1'b0,
            32'h1234_000C, 32'h1234_000C);

        txn("pul0", 0, 2'b00, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0,
            32'hDEAD_BEEF, 32'h0);
        txn("msk0", 0, 2'b00, 32'hDEAD_BEEF, 32'h0, 1'b0,
            32'h0, 32'h0);

        // Held request on the pulse channel: one pulse every 2 cycles.
        drive(0, 2'b00, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, 32'hDEAD_BEEF);
        tick();
        chk("hold_e0_ack", {31'd0, ack[0]}, 32'd1);
        tick();
        pop_chk("hold_p1");
        sb.push_back('{0, 1'b0, 32'hDEAD_BEEF});
        tick();
        chk("hold_e2_ack", {31'd0, ack[0]}, 32'd1);
        chk("hold_e2_data", dval(0), 32'h0);
        chk("hold_e2_upd", {31'd0, upd[0]}, 32'd0);
        tick();
        pop_chk("hold_p2");
        req[0] = 1'b0;
        tick();
        chk("hold_e4_data", dval(0), 32'h0);
        chk("hold_e4_ack", {31'd0, ack[0]}, 32'd0);

        txn("lock2", 2, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
            32'hA5A5_0000, 32'hA5A5_0000);

        // Abort: req drops while ack is high.
        req[1]           = 1'b1;
        op[3:2]          = 2'b00;
        wdata[1*W +: W]  = 32'h0;
        wmask[1*W +: W]  = 32'hFFFF_FFFF;
        tick();
        chk("abt_e0_ack", {31'd0, ack[1]}, 32'd1);
        req[1] = 1'b0;
        tick();
        chk("abt_ack", {31'd0, ack[1]}, 32'd0);
        chk("abt_upd", {31'd0, upd[1]}, 32'd0);
        chk("abt_err", {31'd0, err[1]}, 32'd0);
        chk("abt_data", dval(1), 32'h1234_000C);
        tick();
        chk("abt_upd2", {31'd0, upd[1]}, 32'd0);

        // Async reset in ACK state: no commit, restart from IDLE.
        req[1] = 1'b1;
        tick();
        chk("mrst_e0_ack", {31'd0, ack[1]}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mrst_ack", {31'd0, ack[1]}, 32'd0);
        chk("mrst_d1", dval(1), 32'h0000_00FF);
        #2 reset = 1'b0;
        tick();
        chk("mrst_re_ack", {31'd0, ack[1]}, 32'd1);
        chk("mrst_re_upd", {31'd0, upd[1]}, 32'd0);
        chk("mrst_re_d1", dval(1), 32'h0000_00FF);
        req[1] = 1'b0;
        tick();
        chk("mrst_end_upd", {31'd0, upd[1]}, 32'd0);
        chk("mrst_end_d1", dval(1), 32'h0000_00FF);

        // Concurrent commits on all channels.
        drive(0, 2'b00, 32'h0000_0011, 32'hFFFF_FFFF, 1'b0, 32'h0000_0011);
        drive(1, 2'b01, 32'h0000_0100, 32'hFFFF_FFFF, 1'b0, 32'h0000_01FF);
        drive(2, 2'b11, 32'h0000_FFFF, 32'h0000_00FF, 1'b0, 32'hA5A5_00FF);
        tick();
        chk("cc_e0_ack", {29'd0, ack}, 32'd7);
        tick();
        pop_chk("cc0");
        pop_chk("cc1");
        pop_chk("cc2");
        req = '0;
        tick();
        chk("cc_d0_after", dval(0), 32'h0);
        chk("cc_d2_after", dval(2), 32'hA5A5_00FF);
        chk("sb_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
